reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_if.sv | 25 ++
 rtl/reg_write_arbiter.sv | 100 ++++++++++
 tb/tb_reg_write_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - ALU/load writeback requests and register file write port bundle
interface reg_write_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        starved;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, wr_en, wr_reg, wr_data, starved
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, wr_en, wr_reg, wr_data, starved
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register file write port arbiter with starvation guard
module reg_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic                 clk,
    input logic                 rst,
    reg_write_arbiter_if.slave  bus
);
    typedef enum logic {
        MEM_PRIO = 1'b0,
        ALU_PRIO = 1'b1
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state;
    state_t      state_next;
    logic [2:0]  starve_cnt;
    logic [2:0]  starve_cnt_next;
    logic        alu_gnt;
    logic        mem_gnt;
    logic        starved_q;
    logic        wr_en_q;
    logic [4:0]  wr_reg_q;
    logic [31:0] wr_data_q;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    // State and starvation counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MEM_PRIO;
            starve_cnt <= 3'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Next state: count ALU losses, promote the ALU once the loss run reaches the limit
    always_comb begin
        starve_cnt_next = 3'd0;
        state_next      = state;
        if (bus.alu_valid && mem_gnt) begin
            starve_cnt_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 3'd1;
        end
        case (state)
            MEM_PRIO: if (starve_cnt_next == LIMIT) state_next = ALU_PRIO;
            ALU_PRIO: if (alu_gnt || !bus.alu_valid) state_next = MEM_PRIO;
            default:  state_next = MEM_PRIO;
        endcase
    end

    // Outputs: grants depend only on valids and state, and are suppressed during reset
    always_comb begin
        alu_gnt   = 1'b0;
        mem_gnt   = 1'b0;
        starved_q = (state == ALU_PRIO);
        if (!rst) begin
            if (state == ALU_PRIO) begin
                alu_gnt = bus.alu_valid;
                mem_gnt = bus.mem_valid && !bus.alu_valid;
            end else begin
                mem_gnt = bus.mem_valid;
                alu_gnt = bus.alu_valid && !bus.mem_valid;
            end
        end
    end

    assign sel_rd   = alu_gnt ? bus.alu_rd   : bus.mem_rd;
    assign sel_data = alu_gnt ? bus.alu_data : bus.mem_data;

    // Single-cycle write register; writes to r0 are accepted but squashed to all-zero
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= 5'd0;
            wr_data_q <= 32'd0;
        end else if (alu_gnt || mem_gnt) begin
            if (sel_rd == 5'd0) begin
                wr_en_q   <= 1'b0;
                wr_reg_q  <= 5'd0;
                wr_data_q <= 32'd0;
            end else begin
                wr_en_q   <= 1'b1;
                wr_reg_q  <= sel_rd;
                wr_data_q <= sel_data;
            end
        end else begin
            wr_en_q <= 1'b0;
        end
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.mem_ready = mem_gnt;
    assign bus.starved   = starved_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_reg    = wr_reg_q;
    assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;
    localparam int LIMIT = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    reg_write_arbiter_if bus ();

    reg_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariants that must hold on every cycle of every test
    always @(negedge clk) begin
        n_checks = n_checks + 2;
        if (bus.alu_ready && bus.mem_ready) begin
            n_fail++;
            $display("FAIL both_ready: alu_ready=%0b mem_ready=%0b required not both 1", bus.alu_ready, bus.mem_ready);
        end
        if (bus.wr_en && bus.wr_reg == 5'd0) begin
            n_fail++;
            $display("FAIL wr_en_r0: wr_en=1 with wr_reg=0");
        end
    end

    task automatic idle_cycle();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h5;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_data = 32'h6;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready: got %0b want 0", bus.alu_ready); end
        n_checks++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready: got %0b want 0", bus.mem_ready); end
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %0b want 0", bus.wr_en); end
        n_checks++; if (bus.wr_reg !== 5'd0) begin n_fail++; $display("FAIL rst_wr_reg: got %0d want 0", bus.wr_reg); end
        n_checks++; if (bus.wr_data !== 32'd0) begin n_fail++; $display("FAIL rst_wr_data: got %0h want 0", bus.wr_data); end
        n_checks++; if (bus.starved !== 1'b0) begin n_fail++; $display("FAIL rst_starved: got %0b want 0", bus.starved); end
        @(posedge clk); #1;
    endtask

    // First cycle out of reset is a single ALU write
    task automatic test_single_alu();
        rst = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready_first: got %0b want 1", bus.alu_ready); end
        n_checks++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL mem_ready_first: got %0b want 0", bus.mem_ready); end
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL alu_wr_en: got %0b want 1", bus.wr_en); end
        n_checks++; if (bus.wr_reg !== 5'd5) begin n_fail++; $display("FAIL alu_wr_reg: got %0d want 5", bus.wr_reg); end
        n_checks++; if (bus.wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wr_data: got %0h want deadbeef", bus.wr_data); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_wr_en: got %0b want 0", bus.wr_en); end
        n_checks++; if (bus.wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_wr_hold: got %0h want deadbeef", bus.wr_data); end
        @(posedge clk); #1;
    endtask

    // Both requesting continuously: three load wins, then one forced ALU win
    task automatic test_starvation();
        logic [4:0] prev_rd;
        bit exp_alu [5] = '{0, 0, 0, 1, 0};
        idle_cycle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA0A0;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'hB0B0;
        prev_rd = 5'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.alu_ready !== exp_alu[i]) begin n_fail++; $display("FAIL starve_alu_ready[%0d]: got %0b want %0b", i, bus.alu_ready, exp_alu[i]); end
            n_checks++; if (bus.mem_ready !== !exp_alu[i]) begin n_fail++; $display("FAIL starve_mem_ready[%0d]: got %0b want %0b", i, bus.mem_ready, !exp_alu[i]); end
            n_checks++; if (bus.starved !== exp_alu[i]) begin n_fail++; $display("FAIL starve_flag[%0d]: got %0b want %0b", i, bus.starved, exp_alu[i]); end
            if (i > 0) begin
                n_checks++; if (bus.wr_reg !== prev_rd) begin n_fail++; $display("FAIL starve_wr_reg[%0d]: got %0d want %0d", i, bus.wr_reg, prev_rd); end
            end
            prev_rd = exp_alu[i] ? 5'd3 : 5'd4;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rd_zero();
        idle_cycle();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h1234;
        @(negedge clk);
        n_checks++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL r0_mem_ready: got %0b want 1", bus.mem_ready); end
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL r0_wr_en: got %0b want 0", bus.wr_en); end
        n_checks++; if (bus.wr_reg !== 5'd0) begin n_fail++; $display("FAIL r0_wr_reg: got %0d want 0", bus.wr_reg); end
        n_checks++; if (bus.wr_data !== 32'd0) begin n_fail++; $display("FAIL r0_wr_data: got %0h want 0", bus.wr_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_same_rd();
        idle_cycle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'd2;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'd1;
        @(negedge clk);
        n_checks++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL same_rd_mem_first: got %0b want 1", bus.mem_ready); end
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL same_rd_alu_second: got %0b want 1", bus.alu_ready); end
        n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_reg !== 5'd7 || bus.wr_data !== 32'd1) begin n_fail++; $display("FAIL same_rd_write1: got en=%0b reg=%0d data=%0h want 1/7/1", bus.wr_en, bus.wr_reg, bus.wr_data); end
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_reg !== 5'd7 || bus.wr_data !== 32'd2) begin n_fail++; $display("FAIL same_rd_write2: got en=%0b reg=%0d data=%0h want 1/7/2", bus.wr_en, bus.wr_reg, bus.wr_data); end
        @(posedge clk); #1;
    endtask

    // Reset lands after two ALU losses; the loss count must restart from zero
    task automatic test_reset_mid();
        bit exp_alu [4] = '{0, 0, 0, 1};
        idle_cycle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h22;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got alu=%0b mem=%0b want 0/0", bus.alu_ready, bus.mem_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %0b want 0", bus.wr_en); end
                n_checks++; if (bus.starved !== 1'b0) begin n_fail++; $display("FAIL midrst_starved: got %0b want 0", bus.starved); end
            end
            n_checks++; if (bus.alu_ready !== exp_alu[i]) begin n_fail++; $display("FAIL midrst_alu_ready[%0d]: got %0b want %0b", i, bus.alu_ready, exp_alu[i]); end
            @(posedge clk); #1;
        end
    endtask

    // Random traffic against a loss-run model; requesters hold requests until accepted
    task automatic test_random();
        int       loss_run;
        bit       m_en;
        bit [4:0] m_reg;
        bit [31:0] m_data;
        bit       a_pend, m_pend;
        bit [4:0] a_rd, mm_rd;
        bit [31:0] a_dat, mm_dat;
        bit       alu_prio, exp_a, exp_m, do_rst;
        idle_cycle();
        @(negedge clk);
        loss_run = 0; m_en = bus.wr_en; m_reg = bus.wr_reg; m_data = bus.wr_data;
        m_en = 1'b0;
        a_pend = 0; m_pend = 0; a_rd = 0; mm_rd = 0; a_dat = 0; mm_dat = 0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!a_pend && $urandom_range(0, 1) == 1) begin
                a_pend = 1; a_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); a_dat = $urandom;
            end
            if (!m_pend && $urandom_range(0, 9) < 8) begin
                m_pend = 1; mm_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); mm_dat = $urandom;
            end
            do_rst = ($urandom_range(0, 39) == 0);
            rst = do_rst;
            bus.alu_valid = a_pend; bus.alu_rd = a_rd; bus.alu_data = a_dat;
            bus.mem_valid = m_pend; bus.mem_rd = mm_rd; bus.mem_data = mm_dat;
            @(negedge clk);
            alu_prio = (loss_run == LIMIT);
            exp_a = 0; exp_m = 0;
            if (!do_rst) begin
                if (alu_prio) begin exp_a = a_pend; exp_m = m_pend && !a_pend; end
                else begin exp_m = m_pend; exp_a = a_pend && !m_pend; end
            end
            n_checks++; if (bus.alu_ready !== exp_a) begin n_fail++; $display("FAIL rnd_alu_ready@%0d: got %0b want %0b", cyc, bus.alu_ready, exp_a); end
            n_checks++; if (bus.mem_ready !== exp_m) begin n_fail++; $display("FAIL rnd_mem_ready@%0d: got %0b want %0b", cyc, bus.mem_ready, exp_m); end
            n_checks++; if (bus.starved !== alu_prio) begin n_fail++; $display("FAIL rnd_starved@%0d: got %0b want %0b", cyc, bus.starved, alu_prio); end
            n_checks++; if (bus.wr_en !== m_en) begin n_fail++; $display("FAIL rnd_wr_en@%0d: got %0b want %0b", cyc, bus.wr_en, m_en); end
            n_checks++; if (bus.wr_reg !== m_reg || bus.wr_data !== m_data) begin n_fail++; $display("FAIL rnd_wr@%0d: got reg=%0d data=%0h want reg=%0d data=%0h", cyc, bus.wr_reg, bus.wr_data, m_reg, m_data); end
            if (do_rst) begin
                loss_run = 0; m_en = 0; m_reg = 0; m_data = 0;
            end else begin
                loss_run = (a_pend && exp_m) ? loss_run + 1 : 0;
                if (exp_a || exp_m) begin
                    m_reg  = exp_a ? a_rd : mm_rd;
                    m_data = exp_a ? a_dat : mm_dat;
                    m_en   = (m_reg != 0);
                    if (m_reg == 0) m_data = 0;
                end else begin
                    m_en = 0;
                end
            end
            @(posedge clk); #1;
            if (exp_a) a_pend = 0;
            if (exp_m) m_pend = 0;
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
        test_reset();
        test_single_alu();
        test_starvation();
        test_rd_zero();
        test_same_rd();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
